// File: rtl/uart_tx_fifo.sv
// UART transmitter with a FIFO_DEPTH-word valid/ready FIFO: runtime parity (none/odd/even) and 1/2 stop bits; tx low 1 cycle after accept, in_ready drops when the FIFO is full.
// Define UART_TX_BREAK_EN to add line-break generation (break_req) with a one-bit mark-after-break.
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    par_mode,
  input  logic                          stop2,
  input  logic                          break_req,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [AW:0]   FULL      = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_MARK
  } state_t;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          level_q, level_d;
  logic                 push, pop, fifo_ne;
  logic [DATA_BITS-1:0] head;

  state_t               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 par_en_q, par_en_d;
  logic                 stop2_q, stop2_d;
  logic                 tx_q, tx_d;
  logic                 term, at_boundary, brk;

`ifdef UART_TX_BREAK_EN
  assign brk = break_req;
`else
  logic unused_break;
  assign unused_break = break_req;
  assign brk          = 1'b0;
`endif

  assign in_ready   = (level_q != FULL);
  assign push       = in_valid && in_ready;
  assign fifo_ne    = (level_q != '0);
  assign head       = mem_q[rd_ptr_q];
  assign term       = (baud_q == BAUD_LAST);
  assign busy       = (state_q != S_IDLE) || fifo_ne;
  assign tx         = tx_q;
  assign fifo_level = level_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + (AW+1)'(1);
    else if (!push && pop) level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
      level_q   <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // IDLE and the end of a frame share one decision, so back-to-back frames have no gap.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    at_boundary = 1'b0;
    case (state_q)
      S_IDLE:   at_boundary = 1'b1;
      S_START:  if (term) state_d = S_DATA;
      S_DATA:   if (term && bit_q == DATA_LAST) state_d = par_en_q ? S_PARITY : S_STOP;
      S_PARITY: if (term) state_d = S_STOP;
      S_STOP:   if (term && bit_q == {3'b000, stop2_q}) at_boundary = 1'b1;
`ifdef UART_TX_BREAK_EN
      S_BREAK:  if (!brk) state_d = S_MARK;
      S_MARK:   if (term) at_boundary = 1'b1;
`endif
      default:  state_d = S_IDLE;
    endcase
    if (at_boundary) begin
      if (brk) begin
        state_d = S_BREAK;
      end else if (fifo_ne) begin
        state_d = S_START;
        pop     = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_comb begin
    baud_d    = (state_q == S_IDLE || state_q == S_BREAK || term) ? '0 : baud_q + BW'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;
    stop2_d   = stop2_q;
    if (state_d != state_q) bit_d = '0;
    else if (term && (state_q == S_DATA || state_q == S_STOP)) bit_d = bit_q + 4'd1;
    if (pop) begin
      shift_d   = head;
      par_en_d  = par_mode[0] ^ par_mode[1];
      par_bit_d = (par_mode == 2'b01) ? ~^head : ^head;
      stop2_d   = stop2;
    end else if (state_q == S_DATA && term) begin
      shift_d = shift_q >> 1;
    end
    case (state_d)
      S_START, S_BREAK: tx_d = 1'b0;
      S_DATA:           tx_d = shift_d[0];
      S_PARITY:         tx_d = par_bit_q;
      default:          tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a serial-waveform queue model and hand-computed pins.
module tb_uart_tx_fifo;
  localparam int DB = 8, CPB = 4, DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid, in_ready;
  logic [1:0] par_mode;
  logic       stop2, break_req, tx, busy;
  logic [2:0] fifo_level;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .par_mode(par_mode), .stop2(stop2), .break_req(break_req), .tx(tx), .busy(busy),
    .fifo_level(fifo_level)
  );

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queued words plus the per-cycle tx values still to come for the current frame.
  int  mq[$];
  int  line[$];
  bit  in_brk, acc;
  int  exp_tx, exp_busy, exp_lvl, exp_rdy;

  task automatic build_frame(input int w);
    int bits[$];
    bits.push_back(0);
    for (int i = 0; i < DB; i++) bits.push_back((w >> i) & 1);
    if (par_mode == 2'b01) bits.push_back(($countones(w) % 2 == 0) ? 1 : 0);
    if (par_mode == 2'b10) bits.push_back(($countones(w) % 2 == 1) ? 1 : 0);
    bits.push_back(1);
    if (stop2) bits.push_back(1);
    foreach (bits[i]) for (int k = 0; k < CPB; k++) line.push_back(bits[i]);
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        line.delete();
        in_brk = 1'b0;
      end else begin
        acc = in_valid && (mq.size() < DEPTH);
        if (line.size() > 0) void'(line.pop_front());
        if (line.size() == 0) begin
`ifdef UART_TX_BREAK_EN
          if (break_req) in_brk = 1'b1;
          else if (in_brk) begin
            in_brk = 1'b0;
            for (int k = 0; k < CPB; k++) line.push_back(1);
          end else
`endif
          if (mq.size() > 0) build_frame(mq.pop_front());
        end
        if (acc) mq.push_back(int'(in_data));
      end
      exp_tx   = (line.size() > 0) ? line[0] : (in_brk ? 0 : 1);
      exp_busy = (in_brk || line.size() != 0 || mq.size() != 0) ? 1 : 0;
      exp_lvl  = mq.size();
      exp_rdy  = (mq.size() != DEPTH) ? 1 : 0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("tx", tx, exp_tx);
      chk("busy", busy, exp_busy);
      chk("level", fifo_level, exp_lvl);
      chk("ready", in_ready, exp_rdy);
    end
  end

  logic cap [0:127];

  task automatic capture(input int n, output int bcnt);
    bcnt = 0;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      cap[j] = tx;
      if (busy) bcnt++;
    end
  endtask

  task automatic send(input logic [7:0] w);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("idle_wait", busy, 0);
  endtask

  int bc, nacc, w;
  logic rdy;
  logic [9:0] mid;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; par_mode = 2'b00; stop2 = 1'b0; break_req = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_tx", tx, 1); chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0); chk("rst_ready", in_ready, 1);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // 8N1 frame of 0x55: mid-bit samples start..stop, 40-cycle frame plus one queued cycle
    send(8'h55);
    capture(45, bc);
    for (int i = 0; i < 10; i++) mid[i] = cap[1 + i*CPB + CPB/2];
    chk("t1_bits", mid, 10'h2AA);
    chk("t1_busy", bc, 41);
    wait_idle();

    par_mode = 2'b10;
    send(8'h07);
    capture(50, bc);
    chk("even_par", cap[39], 1);
    chk("even_busy", bc, 45);
    wait_idle();

    par_mode = 2'b01;
    send(8'h07);
    capture(50, bc);
    chk("odd_par", cap[39], 0);
    wait_idle();

    stop2 = 1'b1;
    send(8'h07);
    capture(55, bc);
    chk("stop2_busy", bc, 49);
    chk("stop2_hi", {cap[41], cap[44], cap[45], cap[48]}, 4'hF);
    wait_idle();

    // Fill the FIFO: the transmitter drains one word immediately unless a break stalls it
    par_mode = 2'b00; stop2 = 1'b0; nacc = 0; w = 1;
    @(posedge clk); #1;
`ifdef UART_TX_BREAK_EN
    break_req = 1'b1;
`endif
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_data = 8'(w);
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) begin nacc++; w++; end
      if (!in_ready || w > 6) break;
    end
    in_valid = 1'b0;
`ifdef UART_TX_BREAK_EN
    chk("fill_accepts", nacc, 4);
`else
    chk("fill_accepts", nacc, 5);
`endif
    chk("fill_level", fifo_level, 4);
    chk("fill_ready", in_ready, 0);
    break_req = 1'b0;
    wait_idle();

    // Reset in mid-DATA with two words queued
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 8'hA0 + 8'(k);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre_rst_level", fifo_level, 2);
    repeat (8) @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("arst_tx", tx, 1); chk("arst_busy", busy, 0); chk("arst_level", fifo_level, 0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("post_rst_tx", tx, 1); chk("post_rst_busy", busy, 0);

    // Parity mode change mid-frame applies only to the next frame
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'h3C;
    @(posedge clk); #1;
    in_data = 8'hC3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    fork
      capture(100, bc);
      begin repeat (10) @(posedge clk); #1; par_mode = 2'b10; end
    join
    chk("parchg_busy", bc, 84);
    chk("parchg_f1_stop", cap[38], 1);
    chk("parchg_f2_par", cap[78], 0);
    wait_idle();
    par_mode = 2'b00;

    // Break request with 0xA5 queued
    @(posedge clk); #1;
    break_req = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    fork
      capture(70, bc);
      begin repeat (19) @(posedge clk); #1; break_req = 1'b0; end
    join
`ifdef UART_TX_BREAK_EN
    chk("break_seq", {cap[0], cap[19], cap[20], cap[23], cap[24]}, 5'b00110);
`else
    chk("break_ignored", {cap[0], cap[1], cap[5]}, 3'b101);
`endif
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
